// File: rtl/if_fetch_unit_if.sv
// Instruction-memory read port between the fetch stage and imem.
// The fetch stage holds req/addr; memory returns ack/rdata.
interface if_fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;

  modport master (
    output req,
    output addr,
    input  ack,
    input  rdata
  );

  modport slave (
    input  req,
    input  addr,
    output ack,
    output rdata
  );
endinterface

// File: rtl/if_fetch_unit.sv
// Instruction fetch stage: PC, imem req/ack, stall hold buffer and
// redirect handling, feeding one-cycle write pulses to the IF/ID buffer.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   redirect_valid,
  input  logic [31:0]            redirect_pc,
  if_fetch_unit_if.master        imem,
  output logic [31:0]            pc_4_out,
  output logic [31:0]            ins_out,
  output logic                   if_id_reg_ctrl
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_HOLD
  } state_t;

  state_t      r_state;
  logic [31:0] r_pc;
  logic [31:0] r_pc_4;
  logic [31:0] r_ins;
  logic        r_ctrl;
  logic [31:0] r_hold_ins;
  logic        r_pend;
  logic [31:0] r_pend_pc;

  logic [31:0] w_tgt;
  logic [31:0] w_pc_next;

  assign w_tgt     = {redirect_pc[31:2], 2'b00};
  assign w_pc_next = r_pc + 32'd4;

  assign imem.req  = rst_n && (r_state == S_REQ);
  assign imem.addr = r_pc;

  assign pc_4_out       = r_pc_4;
  assign ins_out        = r_ins;
  assign if_id_reg_ctrl = r_ctrl;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_pc_4     <= 32'd0;
      r_ins      <= 32'd0;
      r_ctrl     <= 1'b0;
      r_hold_ins <= 32'd0;
      r_pend     <= 1'b0;
      r_pend_pc  <= 32'd0;
    end else begin
      r_ctrl <= 1'b0;
      case (r_state)
        S_IDLE: begin
          r_state <= S_REQ;
        end
        S_REQ: begin
          if (imem.ack) begin
            if (r_pend || redirect_valid) begin
              // a redirect in the ack cycle is newer than the latched one
              r_pc   <= redirect_valid ? w_tgt : r_pend_pc;
              r_pend <= 1'b0;
            end else if (!stall) begin
              r_ins  <= imem.rdata;
              r_pc_4 <= w_pc_next;
              r_ctrl <= 1'b1;
              r_pc   <= w_pc_next;
            end else begin
              r_hold_ins <= imem.rdata;
              r_state    <= S_HOLD;
            end
          end else if (redirect_valid) begin
            r_pend    <= 1'b1;
            r_pend_pc <= w_tgt;
          end
        end
        S_HOLD: begin
          if (redirect_valid) begin
            r_pc    <= w_tgt;
            r_state <= S_REQ;
          end else if (!stall) begin
            r_ins   <= r_hold_ins;
            r_pc_4  <= w_pc_next;
            r_ctrl  <= 1'b1;
            r_pc    <= w_pc_next;
            r_state <= S_REQ;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
